// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of a synchronized PWM input, classifies the
// duty/direction into a switch code and flags frequency range and stuck-input conditions.
`timescale 1ns/1ps
module pwm_capture #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_PERIOD = 5000,
  parameter int unsigned MAX_PERIOD = 50000,
  parameter int unsigned TIMEOUT    = (1 << CNT_W) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             dir_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             stuck_hi,
  output logic             stuck_lo,
  output logic [2:0]       psw_rec
);

  localparam int unsigned      XW     = CNT_W + 3;
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] ToLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MinP   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MaxP   = CNT_W'(MAX_PERIOD);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StStuck} state_e;

  logic pwm_m_q, pwm_s_q, pwm_d_q;
  logic dir_m_q, dir_s_q;

  state_e           state_q;
  logic [CNT_W-1:0] hcnt_q, lcnt_q, tcnt_q;
  logic             nopub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_m_q <= 1'b0;
      pwm_s_q <= 1'b0;
      pwm_d_q <= 1'b0;
      dir_m_q <= 1'b0;
      dir_s_q <= 1'b0;
    end else begin
      pwm_m_q <= pwm_in;
      pwm_s_q <= pwm_m_q;
      pwm_d_q <= pwm_s_q;
      dir_m_q <= dir_in;
      dir_s_q <= dir_m_q;
    end
  end

  logic rise, fall, edge_det;
  assign rise     = pwm_s_q & ~pwm_d_q;
  assign fall     = ~pwm_s_q & pwm_d_q;
  assign edge_det = rise | fall;

  logic [CNT_W-1:0] hcnt_inc, lcnt_inc, tcnt_inc;
  logic [CNT_W:0]   sum;
  logic             sum_sat;
  logic [CNT_W-1:0] per_new;
  logic             fok_new;
  logic [XW-1:0]    h8, p1, p3, p5, p7;
  logic [1:0]       cls;
  logic [2:0]       psw_new;
  logic             timeout_hit, stuck_ev;

  always_comb begin
    hcnt_inc = (hcnt_q == CntMax) ? hcnt_q : hcnt_q + 1'b1;
    lcnt_inc = (lcnt_q == CntMax) ? lcnt_q : lcnt_q + 1'b1;
    tcnt_inc = (tcnt_q == CntMax) ? tcnt_q : tcnt_q + 1'b1;

    // The publishing cycle itself still belongs to the low phase.
    sum     = {1'b0, hcnt_q} + {1'b0, lcnt_inc};
    sum_sat = sum[CNT_W];
    per_new = sum_sat ? CntMax : sum[CNT_W-1:0];
    fok_new = !sum_sat && (per_new >= MinP) && (per_new <= MaxP);

    h8 = {hcnt_q, 3'b000};
    p1 = {3'b000, per_new};
    p3 = p1 + (p1 << 1);
    p5 = p1 + (p1 << 2);
    p7 = (p1 << 3) - p1;

    cls = 2'd0;
    if (h8 >= p1 && h8 < p3) begin
      cls = 2'd1;
    end else if (h8 >= p3 && h8 < p5) begin
      cls = 2'd2;
    end else if (h8 >= p5 && h8 < p7) begin
      cls = 2'd3;
    end

    if (cls == 2'd0) begin
      psw_new = 3'b111;
    end else if (dir_s_q) begin
      psw_new = {1'b0, cls} + 3'd3;
    end else begin
      psw_new = {1'b0, cls};
    end

    // An edge in the same cycle always wins over the timeout.
    timeout_hit = (tcnt_q >= ToLast) && !edge_det;
    stuck_ev    = timeout_hit && (state_q != StStuck);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hcnt_q     <= '0;
      lcnt_q     <= '0;
      tcnt_q     <= '0;
      nopub_q    <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      freq_ok    <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
      psw_rec    <= 3'b000;
    end else begin
      meas_valid <= 1'b0;
      tcnt_q     <= edge_det ? '0 : tcnt_inc;

      if (stuck_ev) begin
        state_q    <= StStuck;
        stuck_hi   <= pwm_s_q;
        stuck_lo   <= ~pwm_s_q;
        psw_rec    <= {3{pwm_s_q}};
        freq_ok    <= 1'b0;
        meas_valid <= 1'b1;
        nopub_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rise) begin
              hcnt_q  <= '0;
              lcnt_q  <= '0;
              state_q <= StHigh;
            end
          end
          StHigh: begin
            hcnt_q <= hcnt_inc;
            if (fall) begin
              state_q <= StLow;
            end
          end
          StLow: begin
            if (rise) begin
              if (!nopub_q) begin
                period     <= per_new;
                high_time  <= hcnt_q;
                freq_ok    <= fok_new;
                psw_rec    <= psw_new;
                meas_valid <= 1'b1;
              end
              hcnt_q  <= '0;
              lcnt_q  <= '0;
              nopub_q <= 1'b0;
              state_q <= StHigh;
            end else begin
              lcnt_q <= lcnt_inc;
            end
          end
          StStuck: begin
            if (edge_det) begin
              hcnt_q   <= '0;
              lcnt_q   <= '0;
              stuck_hi <= 1'b0;
              stuck_lo <= 1'b0;
              // Leaving on a falling edge lands mid-period; its first rise must not publish.
              nopub_q  <= fall;
              state_q  <= rise ? StHigh : StLow;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: expected publishes are queued as PWM periods are driven and
// compared when meas_valid pulses.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int unsigned TO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic        dir_in = 1'b0;
  logic [15:0] period, high_time;
  logic        meas_valid, freq_ok, stuck_hi, stuck_lo;
  logic [2:0]  psw_rec;

  typedef struct packed {
    logic [15:0] per;
    logic [15:0] hi;
    logic        fok;
    logic [2:0]  psw;
    logic        shi;
    logic        slo;
  } exp_t;

  exp_t        q[$];
  exp_t        pend;
  bit          pend_v = 1'b0;
  logic [15:0] last_per = '0;
  logic [15:0] last_hi = '0;
  int          checks = 0;
  int          errors = 0;
  exp_t        mon_e, mon_g;

  pwm_capture #(
    .CNT_W      (16),
    .MIN_PERIOD (100),
    .MAX_PERIOD (1000),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .dir_in     (dir_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .freq_ok    (freq_ok),
    .stuck_hi   (stuck_hi),
    .stuck_lo   (stuck_lo),
    .psw_rec    (psw_rec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] per, input logic [15:0] hi, input logic fok,
                              input logic [2:0] psw, input logic shi, input logic slo);
    exp_t e;
    e.per = per;
    e.hi  = hi;
    e.fok = fok;
    e.psw = psw;
    e.shi = shi;
    e.slo = slo;
    return e;
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pend();
    q.push_back(pend);
    last_per = pend.per;
    last_hi  = pend.hi;
    pend_v   = 1'b0;
  endtask

  // One PWM period starting with a rise; that rise publishes the previous period, if any.
  // nd is the direction applied from the falling edge on, i.e. seen at this period's publish.
  task automatic run(input int h, input int l, input logic fok, input logic [2:0] psw,
                     input logic nd);
    pwm_in = 1'b1;
    if (pend_v) begin
      push_pend();
      wait_n(2);
      chk("latency_before", 64'(meas_valid), 64'd0);
      wait_n(1);
      chk("latency_pulse", 64'(meas_valid), 64'd1);
      wait_n(h - 3);
    end else begin
      wait_n(h);
    end
    pwm_in = 1'b0;
    dir_in = nd;
    wait_n(l);
    pend   = mk(16'(h + l), 16'(h), fok, psw, 1'b0, 1'b0);
    pend_v = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL spurious_meas_valid: observed=pulse expected=none at %0t", $time);
      end
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        mon_g = mk(period, high_time, freq_ok, psw_rec, stuck_hi, stuck_lo);
        chk("publish", 64'(mon_g), 64'(mon_e));
      end
    end
  end

  initial begin
    wait_n(3);
    chk("rst_period", 64'(period), 64'd0);
    chk("rst_high_time", 64'(high_time), 64'd0);
    chk("rst_meas_valid", 64'(meas_valid), 64'd0);
    chk("rst_freq_ok", 64'(freq_ok), 64'd0);
    chk("rst_stuck", 64'({stuck_hi, stuck_lo}), 64'd0);
    chk("rst_psw", 64'(psw_rec), 64'd0);
    rst_n = 1'b1;
    wait_n(5);

    // 50 % forward, in range
    repeat (4) run(200, 200, 1'b1, 3'b010, 1'b0);
    // reverse 25 % then 75 %
    repeat (2) run(100, 300, 1'b1, 3'b100, 1'b1);
    repeat (2) run(300, 100, 1'b1, 3'b110, 1'b1);
    // too fast, too slow, and both range limits
    repeat (3) run(25, 25, 1'b0, 3'b010, 1'b0);
    repeat (2) run(600, 600, 1'b0, 3'b010, 1'b0);
    run(50, 50, 1'b1, 3'b010, 1'b0);
    run(500, 500, 1'b1, 3'b010, 1'b0);
    // duty outside every band
    run(20, 380, 1'b1, 3'b111, 1'b0);
    run(390, 10, 1'b1, 3'b111, 1'b1);
    // direction flips mid-period
    run(200, 200, 1'b1, 3'b010, 1'b0);
    run(200, 200, 1'b1, 3'b101, 1'b1);
    run(100, 300, 1'b1, 3'b001, 1'b0);

    // stuck low: pending period is never closed
    pend_v = 1'b0;
    wait_n(500);
    chk("stuck_lo_early", 64'(stuck_lo), 64'd0);
    q.push_back(mk(last_per, last_hi, 1'b0, 3'b000, 1'b0, 1'b1));
    wait_n(600);
    chk("stuck_lo_set", 64'(stuck_lo), 64'd1);
    chk("stuck_lo_psw", 64'(psw_rec), 64'd0);
    run(200, 200, 1'b1, 3'b010, 1'b0);
    chk("stuck_lo_clear", 64'(stuck_lo), 64'd0);
    run(200, 200, 1'b1, 3'b010, 1'b0);

    // stuck high: this rise publishes, then timeout
    pwm_in = 1'b1;
    push_pend();
    wait_n(500);
    chk("stuck_hi_early", 64'(stuck_hi), 64'd0);
    q.push_back(mk(last_per, last_hi, 1'b0, 3'b111, 1'b1, 1'b0));
    wait_n(600);
    chk("stuck_hi_set", 64'(stuck_hi), 64'd1);
    chk("stuck_hi_psw", 64'(psw_rec), 64'd7);
    pwm_in = 1'b0;
    wait_n(200);
    chk("stuck_hi_clear", 64'({stuck_hi, stuck_lo}), 64'd0);
    run(200, 200, 1'b1, 3'b010, 1'b0);
    run(400, 400, 1'b1, 3'b010, 1'b0);

    // reset mid-HIGH: outputs clear without a clock edge
    pwm_in = 1'b1;
    push_pend();
    wait_n(100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_period", 64'(period), 64'd0);
    chk("arst_high_time", 64'(high_time), 64'd0);
    chk("arst_flags", 64'({meas_valid, freq_ok, stuck_hi, stuck_lo}), 64'd0);
    chk("arst_psw", 64'(psw_rec), 64'd0);
    pwm_in = 1'b0;
    wait_n(3);
    rst_n = 1'b1;
    wait_n(5);
    run(200, 200, 1'b1, 3'b010, 1'b0);
    run(100, 300, 1'b1, 3'b001, 1'b0);
    pwm_in = 1'b1;
    push_pend();
    wait_n(10);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16, counter and measurement width in bits.
REQ-002 SHALL have parameter MIN_PERIOD, default 5000, shortest legal PWM period in clk cycles (20 kHz at 100 MHz, the MD10C limit).
REQ-003 SHALL have parameter MAX_PERIOD, default 50000, longest legal PWM period in clk cycles.
REQ-004 SHALL have parameter TIMEOUT, default 2^CNT_W-1, number of cycles without an edge before the input is declared stuck.
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port pwm_in, input, 1, asynchronous PWM from the motor driver path (pdcm).
REQ-008 SHALL have port dir_in, input, 1, asynchronous direction level (dir).
REQ-009 SHALL have port period, output, CNT_W, last measured rising-to-rising period in cycles.
REQ-010 SHALL have port high_time, output, CNT_W, last measured high time in cycles.
REQ-011 SHALL have port meas_valid, output, 1, one-cycle pulse when new measurements are published.
REQ-012 SHALL have port freq_ok, output, 1, last period within [MIN_PERIOD, MAX_PERIOD].
REQ-013 SHALL have port stuck_hi and stuck_lo, outputs, 1 each, input held high or low for TIMEOUT cycles.
REQ-014 SHALL have port psw_rec, output, 3, reconstructed switch code: 000 off; 001/010/011 forward 25/50/75 %; 100/101/110 reverse 25/50/75 %; 111 unclassifiable.

Function
REQ-015 SHALL pass pwm_in and dir_in through separate 2-flop synchronizers; all logic uses only the synchronized values (pwm_s, dir_s).
REQ-016 SHALL detect rising and falling edges of pwm_s against a third registered copy.
REQ-017 SHALL implement FSM states IDLE, HIGH, LOW, STUCK.
REQ-018 IDLE: wait for a rising edge, then clear the counters and go to HIGH; no output is published.
REQ-019 HIGH: increment hcnt each cycle; on a falling edge go to LOW.
REQ-020 LOW: increment lcnt each cycle; on a rising edge publish, clear the counters and go to HIGH.
REQ-021 Publish SHALL mean: period = hcnt+lcnt (exact cycle count between consecutive synchronized rising edges); high_time = hcnt; update freq_ok and psw_rec; assert meas_valid for exactly one cycle.
REQ-022 Published outputs SHALL be registered and change on the clk edge after the publishing edge is detected; fixed latency is 3 clk edges from the first edge that samples pwm_in high.
REQ-023 Counters SHALL saturate at 2^CNT_W-1 and never wrap; a sum exceeding that saturates period and forces freq_ok=0.
REQ-024 Classification SHALL use exact compares at width CNT_W+3 on H = 8*high_time and P = period.
REQ-025 Classification bands: 25 % if P <= H < 3P; 50 % if 3P <= H < 5P; 75 % if 5P <= H < 7P; otherwise 111.
REQ-026 On a classified duty, psw_rec SHALL be class (1..3) when dir_s = 0, and class+3 when dir_s = 1, with dir_s sampled at publish.
REQ-027 In HIGH, IDLE or LOW, once TIMEOUT cycles pass without an edge, the FSM SHALL go to STUCK.
REQ-028 On entering STUCK, the block SHALL set stuck_hi or stuck_lo to match pwm_s, set psw_rec=000 if low and 111 if high, set freq_ok=0, pulse meas_valid once, and leave period and high_time unchanged.
REQ-029 STUCK SHALL exit on any edge: a rising edge goes to HIGH with cleared counters; a falling edge goes to LOW with cleared counters and no publish at the next rising edge. Both stuck flags clear on exit.
REQ-030 If a rising edge and a timeout occur in the same cycle, the edge SHALL take priority.
REQ-031 A change of dir_in mid-period SHALL affect only the psw_rec published at the next publish.

Reset
REQ-032 When rst_n = 0, all flops SHALL clear asynchronously: FSM=IDLE, counters=0, synchronizers=0, period=0, high_time=0, meas_valid=0, freq_ok=0, stuck_hi=0, stuck_lo=0, psw_rec=000.
REQ-033 Reset assertion mid-period SHALL discard the partial measurement; after release, the first publish requires two rising edges.

Verification
REQ-034 Scenario: CNT_W=16, MIN_PERIOD=100, MAX_PERIOD=1000; pwm_in period 400 cycles, high 200 cycles, dir_in=0 -> from the 2nd rising edge on, period=400, high_time=200, psw_rec=010, freq_ok=1, one meas_valid per period.
REQ-035 Scenario: period 400, high 100 then high 300, dir_in=1 -> psw_rec=100, then 110 on the first publish after the change.
REQ-036 Scenario: period 50, high 25 -> psw_rec=010, freq_ok=0; with period 1200 -> freq_ok=0.
REQ-037 Scenario: TIMEOUT=500, pwm_in held low -> stuck_lo=1 and psw_rec=000 after 500 cycles, single meas_valid pulse; held high -> stuck_hi=1, psw_rec=111.
REQ-038 Scenario: rst_n pulsed low mid-HIGH -> all outputs 0 immediately with no clk edge needed; the next meas_valid occurs only after two further rising edges.
REQ-039 Scenario: high 20 of period 400 (5 %) -> psw_rec=111; high 390 of period 400 -> psw_rec=111.
